// File: rtl/stack_cpu_core.sv
// Dual-stack CPU core: req/ack instruction fetch, word ops and packed byte-op pairs, stalling OUT port.
// Define STACK_CPU_MUL_EN to enable byte op 0x0C (MUL); otherwise 0x0C is a NOP.
module stack_cpu_core #(
   parameter int unsigned DW     = 16,
   parameter int unsigned AW     = 15,
   parameter int unsigned DDEPTH = 16,
   parameter int unsigned RDEPTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [15:0]   mem_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          halted,
   output logic [1:0]    fault
);

   localparam int unsigned IPW = AW + 1;
   localparam int unsigned DPW = $clog2(DDEPTH);
   localparam int unsigned RPW = $clog2(RDEPTH);

   localparam logic [IPW-1:0] IP_ONE  = IPW'(1);
   localparam logic [IPW-1:0] IP_TWO  = IPW'(2);
   localparam logic [DPW:0]   D_ONE   = (DPW+1)'(1);
   localparam logic [DPW:0]   D_TWO   = (DPW+1)'(2);
   localparam logic [DPW:0]   D_FULL  = (DPW+1)'(DDEPTH);
   localparam logic [DPW-1:0] DI_ONE  = DPW'(1);
   localparam logic [DPW-1:0] DI_TWO  = DPW'(2);
   localparam logic [RPW:0]   R_ONE   = (RPW+1)'(1);
   localparam logic [RPW:0]   R_FULL  = (RPW+1)'(RDEPTH);
   localparam logic [RPW-1:0] RI_ONE  = RPW'(1);

   localparam logic [7:0] OP_OUT  = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_DUP  = 8'h04;
   localparam logic [7:0] OP_SWAP = 8'h05;
   localparam logic [7:0] OP_RET  = 8'h06;
   localparam logic [7:0] OP_DROP = 8'h07;
   localparam logic [7:0] OP_OVER = 8'h08;
   localparam logic [7:0] OP_AND  = 8'h09;
   localparam logic [7:0] OP_OR   = 8'h0A;
   localparam logic [7:0] OP_XOR  = 8'h0B;
`ifdef STACK_CPU_MUL_EN
   localparam logic [7:0] OP_MUL  = 8'h0C;
`endif
   localparam logic [7:0] OP_HALT = 8'h0F;

   typedef enum logic [2:0] {
      S_FETCH, S_WORD, S_BYTE_HI, S_BYTE_LO, S_OUT_WAIT, S_HALT
   } state_t;

   typedef enum logic [1:0] {
      F_NONE = 2'd0, F_DOVF = 2'd1, F_DUNF = 2'd2, F_RSTK = 2'd3
   } fault_t;

   state_t          state;
   state_t          resume;
   fault_t          fault_q;
   logic [IPW-1:0]  ip;
   logic [15:0]     ir;
   logic [DPW:0]    dsp;
   logic [RPW:0]    rsp;
   logic [DW-1:0]   dstk [DDEPTH];
   logic [IPW-1:0]  rstk [RDEPTH];

   logic [DPW-1:0]  dsp_idx, tos_idx, nos_idx;
   logic [RPW-1:0]  rsp_idx, rtos_idx;
   logic [DW-1:0]   tos, nos, push_val, alu_res;
   logic [IPW-1:0]  rtos, off_ext, ip_plus2, target;
   logic [7:0]      cur_byte;
   logic            d_empty, d_lt2, d_full, r_empty, r_full, is_alu;
   fault_t          word_fault, byte_fault;
   state_t          byte_next;

   assign mem_addr = ip[AW:1];
   assign fault    = fault_q;

   assign dsp_idx  = dsp[DPW-1:0];
   assign tos_idx  = dsp_idx - DI_ONE;
   assign nos_idx  = dsp_idx - DI_TWO;
   assign rsp_idx  = rsp[RPW-1:0];
   assign rtos_idx = rsp_idx - RI_ONE;
   assign tos      = dstk[tos_idx];
   assign nos      = dstk[nos_idx];
   assign rtos     = rstk[rtos_idx];

   assign d_empty  = (dsp == '0);
   assign d_lt2    = (dsp < D_TWO);
   assign d_full   = (dsp == D_FULL);
   assign r_empty  = (rsp == '0);
   assign r_full   = (rsp == R_FULL);

   assign push_val = {{(DW-15){1'b0}}, ir[14:0]};
   assign off_ext  = {{(IPW-13){ir[12]}}, ir[12:0]};
   assign ip_plus2 = ip + IP_TWO;
   assign target   = ip_plus2 + off_ext;

   assign cur_byte  = (state == S_BYTE_HI) ? ir[15:8] : ir[7:0];
   assign byte_next = (state == S_BYTE_HI) ? S_BYTE_LO : S_FETCH;

   always_comb begin
      is_alu  = 1'b0;
      alu_res = '0;
      case (cur_byte)
         OP_ADD:  begin is_alu = 1'b1; alu_res = nos + tos; end
         OP_SUB:  begin is_alu = 1'b1; alu_res = nos - tos; end
         OP_AND:  begin is_alu = 1'b1; alu_res = nos & tos; end
         OP_OR:   begin is_alu = 1'b1; alu_res = nos | tos; end
         OP_XOR:  begin is_alu = 1'b1; alu_res = nos ^ tos; end
`ifdef STACK_CPU_MUL_EN
         OP_MUL:  begin is_alu = 1'b1; alu_res = nos * tos; end
`endif
         default: ;
      endcase
   end

   // Stack-depth checks are resolved before execution so a faulting op leaves no side effect.
   always_comb begin
      byte_fault = F_NONE;
      if (is_alu) begin
         if (d_lt2) byte_fault = F_DUNF;
      end else begin
         case (cur_byte)
            OP_OUT, OP_DROP: if (d_empty) byte_fault = F_DUNF;
            OP_SWAP:         if (d_lt2)   byte_fault = F_DUNF;
            OP_DUP: begin
               if (d_empty)     byte_fault = F_DUNF;
               else if (d_full) byte_fault = F_DOVF;
            end
            OP_OVER: begin
               if (d_lt2)       byte_fault = F_DUNF;
               else if (d_full) byte_fault = F_DOVF;
            end
            OP_RET:          if (r_empty) byte_fault = F_RSTK;
            default: ;
         endcase
      end
   end

   always_comb begin
      word_fault = F_NONE;
      if (ir[15]) begin
         if (d_full) word_fault = F_DOVF;
      end else begin
         case (ir[14:13])
            2'b10:   if (r_full)  word_fault = F_RSTK;
            2'b11:   if (d_empty) word_fault = F_DUNF;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         resume    <= S_FETCH;
         fault_q   <= F_NONE;
         ip        <= '0;
         ir        <= '0;
         dsp       <= '0;
         rsp       <= '0;
         mem_req   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         halted    <= 1'b0;
         for (int unsigned i = 0; i < DDEPTH; i++) dstk[i] <= '0;
         for (int unsigned i = 0; i < RDEPTH; i++) rstk[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_req && mem_ack) begin
                  mem_req <= 1'b0;
                  ir      <= mem_rdata;
                  // Odd ip runs only the low byte, whatever the word would decode as.
                  if (ip[0])                        state <= S_BYTE_LO;
                  else if (mem_rdata[15:13] != '0)  state <= S_WORD;
                  else                              state <= S_BYTE_HI;
               end else begin
                  mem_req <= 1'b1;
               end
            end

            S_WORD: begin
               if (word_fault != F_NONE) begin
                  fault_q <= word_fault;
                  halted  <= 1'b1;
                  state   <= S_HALT;
               end else begin
                  state <= S_FETCH;
                  if (ir[15]) begin
                     dstk[dsp_idx] <= push_val;
                     dsp           <= dsp + D_ONE;
                     ip            <= ip_plus2;
                  end else begin
                     case (ir[14:13])
                        2'b01: ip <= target;
                        2'b10: begin
                           rstk[rsp_idx] <= ip_plus2;
                           rsp           <= rsp + R_ONE;
                           ip            <= target;
                        end
                        default: begin
                           dsp <= dsp - D_ONE;
                           ip  <= (tos == '0) ? target : ip_plus2;
                        end
                     endcase
                  end
               end
            end

            S_BYTE_HI, S_BYTE_LO: begin
               if (byte_fault != F_NONE) begin
                  fault_q <= byte_fault;
                  halted  <= 1'b1;
                  state   <= S_HALT;
               end else begin
                  ip    <= ip + IP_ONE;
                  state <= byte_next;
                  if (is_alu) begin
                     dstk[nos_idx] <= alu_res;
                     dsp           <= dsp - D_ONE;
                  end else begin
                     case (cur_byte)
                        OP_OUT: begin
                           out_data  <= tos;
                           out_valid <= 1'b1;
                           dsp       <= dsp - D_ONE;
                           resume    <= byte_next;
                           state     <= S_OUT_WAIT;
                        end
                        OP_DUP: begin
                           dstk[dsp_idx] <= tos;
                           dsp           <= dsp + D_ONE;
                        end
                        OP_SWAP: begin
                           dstk[tos_idx] <= nos;
                           dstk[nos_idx] <= tos;
                        end
                        OP_RET: begin
                           ip    <= rtos;
                           rsp   <= rsp - R_ONE;
                           state <= S_FETCH;
                        end
                        OP_DROP: dsp <= dsp - D_ONE;
                        OP_OVER: begin
                           dstk[dsp_idx] <= nos;
                           dsp           <= dsp + D_ONE;
                        end
                        OP_HALT: begin
                           ip     <= ip;
                           halted <= 1'b1;
                           state  <= S_HALT;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            S_OUT_WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= resume;
               end
            end

            S_HALT: ;

            default: begin
               halted <= 1'b1;
               state  <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Scoreboard bench for stack_cpu_core: an instruction-level reference model predicts fetch
// addresses, OUT values and the final fault; a monitor checks them as the DUT presents them.
`timescale 1ns/1ps
module tb_stack_cpu_core;
   localparam int unsigned DW = 16, AW = 15, DDEPTH = 16, RDEPTH = 8;
   localparam int unsigned MEMW = 512;
`ifdef STACK_CPU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk, rst_n, mem_req, mem_ack, out_valid, out_ready, halted;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_rdata;
   logic [DW-1:0] out_data;
   logic [1:0]    fault;

   stack_cpu_core #(.DW(DW), .AW(AW), .DDEPTH(DDEPTH), .RDEPTH(RDEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .halted(halted), .fault(fault)
   );

   int unsigned checks = 0, errors = 0;
   logic [15:0]   mem [MEMW];
   logic [AW-1:0] exp_fetch [$];
   logic [DW-1:0] exp_out [$];
   logic [1:0]    exp_fault;
   int unsigned   ack_lo = 0, ack_hi = 2, ack_cnt = 0, ready_mode = 0, stall_cnt = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Program memory responder with a random ack delay per fetch
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            mem_ack = 1'b0;
            ack_cnt = $urandom_range(ack_hi, ack_lo);
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = $urandom_range(ack_hi, ack_lo);
         end else if (mem_req) begin
            if (ack_cnt == 0) begin
               mem_ack = 1'b1;
               mem_rdata = mem[mem_addr[8:0]];
            end else ack_cnt--;
         end
      end
   end

   // Output consumer: mode 0 random ready, mode 2 stalls each transfer for 5 cycles
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0) out_ready = ($urandom_range(3, 0) != 0);
         else if (out_valid) begin
            if (stall_cnt >= 5) out_ready = 1'b1;
            else begin out_ready = 1'b0; stall_cnt++; end
         end else begin
            out_ready = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   // Monitor
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d;
   always @(negedge clk) begin
      if (!rst_n) hold_v = 1'b0;
      else begin
         if (mem_req && mem_ack) begin
            if (exp_fetch.size() == 0) check("fetch_unexpected", {17'd0, mem_addr}, 32'hFFFF_FFFF);
            else check("fetch_addr", {17'd0, mem_addr}, {17'd0, exp_fetch.pop_front()});
         end
         if (out_valid) begin
            if (hold_v) check("out_stable", {16'd0, out_data}, {16'd0, hold_d});
            if (out_ready) begin
               if (exp_out.size() == 0) check("out_unexpected", {16'd0, out_data}, 32'hFFFF_FFFF);
               else check("out_data", {16'd0, out_data}, {16'd0, exp_out.pop_front()});
               hold_v = 1'b0;
            end else begin
               hold_v = 1'b1;
               hold_d = out_data;
            end
         end else hold_v = 1'b0;
      end
   end

   // Reference model: interprets the program instruction by instruction
   logic [DW-1:0] m_ds [$];
   logic [15:0]   m_rs [$];
   int unsigned   m_ip;
   bit            m_stop, m_redir;

   function automatic logic [DW-1:0] m_alu(logic [7:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      logic [DW-1:0] r;
      case (op)
         8'h02:   r = a + b;
         8'h03:   r = a - b;
         8'h09:   r = a & b;
         8'h0A:   r = a | b;
         8'h0B:   r = a ^ b;
         default: r = a * b;
      endcase
      return r;
   endfunction

   task automatic m_fault(input logic [1:0] f);
      exp_fault = f;
      m_stop = 1'b1;
   endtask

   task automatic m_byte(input logic [7:0] op);
      logic [DW-1:0] a, b;
      bit alu;
      m_redir = 1'b0;
      alu = (op inside {8'h02, 8'h03, 8'h09, 8'h0A, 8'h0B}) || (MUL_EN && op == 8'h0C);
      if (alu) begin
         if (m_ds.size() < 2) m_fault(2);
         else begin b = m_ds.pop_back(); a = m_ds.pop_back(); m_ds.push_back(m_alu(op, a, b)); end
      end else begin
         case (op)
            8'h01: if (m_ds.size() < 1) m_fault(2); else exp_out.push_back(m_ds.pop_back());
            8'h04: if (m_ds.size() < 1) m_fault(2);
                   else if (m_ds.size() == DDEPTH) m_fault(1);
                   else m_ds.push_back(m_ds[m_ds.size()-1]);
            8'h05: if (m_ds.size() < 2) m_fault(2);
                   else begin b = m_ds.pop_back(); a = m_ds.pop_back(); m_ds.push_back(b); m_ds.push_back(a); end
            8'h06: if (m_rs.size() == 0) m_fault(3);
                   else begin m_ip = m_rs.pop_back(); m_redir = 1'b1; end
            8'h07: if (m_ds.size() < 1) m_fault(2); else void'(m_ds.pop_back());
            8'h08: if (m_ds.size() < 2) m_fault(2);
                   else if (m_ds.size() == DDEPTH) m_fault(1);
                   else m_ds.push_back(m_ds[m_ds.size()-2]);
            8'h0F: m_stop = 1'b1;
            default: ;
         endcase
      end
      if (!m_stop && !m_redir) m_ip = (m_ip + 1) & 32'hFFFF;
   endtask

   task automatic m_word(input logic [15:0] w);
      int unsigned tgt;
      logic [DW-1:0] t;
      tgt = (m_ip + 2 + int'($signed(w[12:0]))) & 32'hFFFF;
      if (w[15]) begin
         if (m_ds.size() == DDEPTH) m_fault(1);
         else begin m_ds.push_back(DW'(w[14:0])); m_ip = m_ip + 2; end
      end else if (w[14:13] == 2'b01) m_ip = tgt;
      else if (w[14:13] == 2'b10) begin
         if (m_rs.size() == RDEPTH) m_fault(3);
         else begin m_rs.push_back(16'(m_ip + 2)); m_ip = tgt; end
      end else begin
         if (m_ds.size() == 0) m_fault(2);
         else begin t = m_ds.pop_back(); m_ip = (t == 0) ? tgt : m_ip + 2; end
      end
   endtask

   task automatic model_run();
      logic [15:0] w;
      m_ds.delete(); m_rs.delete();
      m_ip = 0; m_stop = 1'b0; m_redir = 1'b0; exp_fault = 2'd0;
      for (int s = 0; s < 400 && !m_stop; s++) begin
         w = mem[(m_ip >> 1) % MEMW];
         exp_fetch.push_back(AW'(m_ip >> 1));
         if (m_ip % 2 == 1) m_byte(w[7:0]);
         else if (w[15:13] != 3'b000) m_word(w);
         else begin
            m_byte(w[15:8]);
            if (!m_stop && !m_redir) m_byte(w[7:0]);
         end
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < MEMW; i++) mem[i] = 16'h0F0F;
   endtask

   task automatic start_test(input int unsigned rmode);
      rst_n = 1'b0;
      ready_mode = rmode;
      exp_fetch.delete();
      exp_out.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fault", {30'd0, fault}, 32'd0);
      model_run();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic finish_test(input string name);
      int cyc = 0;
      while (!halted && cyc < 3000) begin @(posedge clk); cyc++; end
      #2;
      check($sformatf("%s_halted", name), {31'd0, halted}, 32'd1);
      check($sformatf("%s_fault", name), {30'd0, fault}, {30'd0, exp_fault});
      repeat (4) @(negedge clk);
      check($sformatf("%s_req_idle", name), {31'd0, mem_req}, 32'd0);
      check($sformatf("%s_fetch_left", name), exp_fetch.size(), 32'd0);
      check($sformatf("%s_out_left", name), exp_out.size(), 32'd0);
   endtask

   task automatic gen_random();
      int unsigned n;
      logic [7:0] hb, lb;
      clear_mem();
      n = $urandom_range(24, 8);
      for (int i = 0; i < int'(n); i++) begin
         if ($urandom_range(1, 0) == 1) mem[i] = 16'h8000 | 16'($urandom_range(32767, 0));
         else begin
            hb = rand_op();
            lb = rand_op();
            mem[i] = {hb, lb};
         end
      end
      mem[n] = 16'h0F0F;
   endtask

   function automatic logic [7:0] rand_op();
      case ($urandom_range(17, 0))
         0, 1:    return 8'h01;
         2, 3:    return 8'h02;
         4:       return 8'h03;
         5:       return 8'h04;
         6:       return 8'h05;
         7:       return 8'h07;
         8:       return 8'h08;
         9:       return 8'h09;
         10:      return 8'h0A;
         11:      return 8'h0B;
         12, 13:  return 8'h0C;
         14:      return 8'h0D;
         15:      return 8'h06;
         16:      return 8'h1F;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      int cyc;
      rst_n = 1'b0;
      clear_mem();

      // ADD then OUT with consumer stalling 5 cycles
      mem[0] = 16'h8005; mem[1] = 16'h8007; mem[2] = 16'h0201; mem[3] = 16'h0F00;
      start_test(2); finish_test("add_stall");

      clear_mem();
      mem[0] = 16'h8003; mem[1] = 16'h800A; mem[2] = 16'h0301; mem[3] = 16'h0F00;
      start_test(0); finish_test("sub");

      clear_mem();
      mem[0] = 16'h8006; mem[1] = 16'h8007; mem[2] = 16'h0C01; mem[3] = 16'h0F00;
      start_test(0); finish_test("mul");

      // cjump taken / not taken, then OUT and DROP on an empty stack
      clear_mem();
      mem[0] = 16'h8000; mem[1] = 16'h6004; mem[4] = 16'h8001; mem[5] = 16'h6004;
      mem[6] = 16'h8009; mem[7] = 16'h0107;
      start_test(0); finish_test("cjump");

      // jump to 0x10, call +8, RET back to 0x12
      clear_mem();
      mem[0] = 16'h200E; mem[8] = 16'h4008; mem[13] = 16'h0600;
      mem[9] = 16'h8055; mem[10] = 16'h010F;
      start_test(0); finish_test("call_ret");

      clear_mem();
      for (int i = 0; i <= int'(DDEPTH); i++) mem[i] = 16'h8000 | 16'(i + 1);
      start_test(0); finish_test("dovf");

      clear_mem();
      mem[0] = 16'h0200;
      start_test(0); finish_test("dunf");

      clear_mem();
      mem[0] = 16'h0600;
      start_test(0); finish_test("ret_empty");

      clear_mem();
      for (int i = 0; i <= int'(RDEPTH); i++) mem[i] = 16'h4000;
      start_test(0); finish_test("rovf");

      // jump to odd address: only the low byte (OUT) of a word-op-looking word runs
      clear_mem();
      mem[0] = 16'h8021; mem[1] = 16'h2001; mem[2] = 16'h9F01; mem[3] = 16'h0F00;
      start_test(0); finish_test("misalign");

      // reset pulse while a delayed fetch is outstanding
      clear_mem();
      mem[0] = 16'h9234; mem[1] = 16'h010F;
      ack_lo = 3; ack_hi = 3;
      start_test(0);
      cyc = 0;
      while (!mem_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("req_before_reset", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_req_drop", {31'd0, mem_req}, 32'd0);
      check("async_valid_drop", {31'd0, out_valid}, 32'd0);
      start_test(0); finish_test("mid_reset");

      ack_lo = 0; ack_hi = 3;
      for (int t = 0; t < 10; t++) begin
         gen_random();
         start_test(0);
         finish_test($sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
